// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Run-time programmable VGA timing generator: porch/sync/visible fields, pixel-clock
// divider, per-axis sync polarity and a shadow config swapped in only at frame boundaries.
module vga_timing_gen #(
  parameter int HW = 12,
  parameter int VW = 11,
  parameter int DW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [DW-1:0] div_i,
  input  logic [HW-1:0] hvis_i,
  input  logic [HW-1:0] hfp_i,
  input  logic [HW-1:0] hsync_i,
  input  logic [HW-1:0] hbp_i,
  input  logic [VW-1:0] vvis_i,
  input  logic [VW-1:0] vfp_i,
  input  logic [VW-1:0] vsync_i,
  input  logic [VW-1:0] vbp_i,
  input  logic          hpol_i,
  input  logic          vpol_i,
  input  logic          upd_i,
  output logic          upd_ack_o,
  output logic          cfg_err_o,
  output logic          pix_tick_o,
  output logic [HW-1:0] pix_x_o,
  output logic [VW-1:0] pix_y_o,
  output logic          de_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [HW+1:0] H_MAX = {2'b00, {HW{1'b1}}};
  localparam logic [VW+1:0] V_MAX = {2'b00, {VW{1'b1}}};
  localparam logic [HW+1:0] H_ONE = {{(HW+1){1'b0}}, 1'b1};
  localparam logic [VW+1:0] V_ONE = {{(VW+1){1'b0}}, 1'b1};

  // Field order in the arrays: visible, front porch, sync, back porch.
  logic [HW-1:0] live_h   [4];
  logic [VW-1:0] live_v   [4];
  logic [HW-1:0] sh_h_reg [4];
  logic [VW-1:0] sh_v_reg [4];
  logic [3:0]    h_zero, v_zero;
  logic [HW+1:0] live_htot, h_sync_beg, h_sync_end, h_total;
  logic [VW+1:0] live_vtot, v_sync_beg, v_sync_end, v_total;
  logic          live_err;

  logic [DW-1:0] sh_div_reg, dcnt_reg;
  logic          sh_hpol_reg, sh_vpol_reg, sh_err_reg;

  state_t        state_reg;
  logic          en_q_reg, pend_reg;
  logic          upd_ack_reg, pix_tick_reg, de_reg, hsync_reg, vsync_reg;
  logic          line_start_reg, frame_start_reg;
  logic [HW-1:0] pix_x_reg, h_nxt;
  logic [VW-1:0] pix_y_reg, v_nxt;

  logic tick, h_last, v_last, frame_wrap, de_nxt, hs_act, vs_act;
  logic en_rise, pend_any, idle_load, run_load, load;

  assign live_h[0] = hvis_i;
  assign live_h[1] = hfp_i;
  assign live_h[2] = hsync_i;
  assign live_h[3] = hbp_i;
  assign live_v[0] = vvis_i;
  assign live_v[1] = vfp_i;
  assign live_v[2] = vsync_i;
  assign live_v[3] = vbp_i;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_field
      assign h_zero[gi] = (live_h[gi] == '0);
      assign v_zero[gi] = (live_v[gi] == '0);
    end
  endgenerate

  assign live_htot = {2'b00, hvis_i} + {2'b00, hfp_i} + {2'b00, hsync_i} + {2'b00, hbp_i};
  assign live_vtot = {2'b00, vvis_i} + {2'b00, vfp_i} + {2'b00, vsync_i} + {2'b00, vbp_i};
  assign live_err  = (|h_zero) | (|v_zero) | (live_htot > H_MAX) | (live_vtot > V_MAX);

  // Region boundaries from the active (shadow) configuration only.
  assign h_sync_beg = {2'b00, sh_h_reg[0]} + {2'b00, sh_h_reg[1]};
  assign h_sync_end = h_sync_beg + {2'b00, sh_h_reg[2]};
  assign h_total    = h_sync_end + {2'b00, sh_h_reg[3]};
  assign v_sync_beg = {2'b00, sh_v_reg[0]} + {2'b00, sh_v_reg[1]};
  assign v_sync_end = v_sync_beg + {2'b00, sh_v_reg[2]};
  assign v_total    = v_sync_end + {2'b00, sh_v_reg[3]};

  assign tick       = (dcnt_reg == sh_div_reg);
  assign h_last     = ({2'b00, pix_x_reg} == h_total - H_ONE);
  assign v_last     = ({2'b00, pix_y_reg} == v_total - V_ONE);
  assign frame_wrap = tick & h_last & v_last;
  assign h_nxt      = h_last ? '0 : pix_x_reg + 1'b1;
  assign v_nxt      = h_last ? (v_last ? '0 : pix_y_reg + 1'b1) : pix_y_reg;
  assign de_nxt     = (h_nxt < sh_h_reg[0]) && (v_nxt < sh_v_reg[0]);
  assign hs_act     = ({2'b00, h_nxt} >= h_sync_beg) && ({2'b00, h_nxt} < h_sync_end);
  assign vs_act     = ({2'b00, v_nxt} >= v_sync_beg) && ({2'b00, v_nxt} < v_sync_end);

  // While idle a request loads at once; while running it waits for the frame wrap.
  assign en_rise   = en_i & ~en_q_reg;
  assign pend_any  = pend_reg | upd_i;
  assign idle_load = (state_reg == IDLE) & (en_rise | pend_any);
  assign run_load  = (state_reg == RUN) & en_i & frame_wrap & pend_any;
  assign load      = idle_load | run_load;

  always_ff @(posedge clk_i) begin
    if (rst_i || load) begin
      for (int i = 0; i < 4; i++) begin
        sh_h_reg[i] <= live_h[i];
        sh_v_reg[i] <= live_v[i];
      end
      sh_div_reg  <= div_i;
      sh_hpol_reg <= hpol_i;
      sh_vpol_reg <= vpol_i;
      sh_err_reg  <= live_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      en_q_reg        <= 1'b0;
      pend_reg        <= 1'b0;
      dcnt_reg        <= '0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      de_reg          <= 1'b0;
      hsync_reg       <= ~hpol_i;
      vsync_reg       <= ~vpol_i;
      upd_ack_reg     <= 1'b0;
      pix_tick_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      en_q_reg        <= en_i;
      pend_reg        <= load ? 1'b0 : pend_any;
      upd_ack_reg     <= load & pend_any;
      pix_tick_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          dcnt_reg  <= '0;
          pix_x_reg <= '0;
          pix_y_reg <= '0;
          de_reg    <= 1'b0;
          hsync_reg <= load ? ~hpol_i : ~sh_hpol_reg;
          vsync_reg <= load ? ~vpol_i : ~sh_vpol_reg;
          state_reg <= (en_i && !(load ? live_err : sh_err_reg)) ? RUN : IDLE;
        end
        RUN: begin
          if (!en_i) begin
            state_reg <= IDLE;
            dcnt_reg  <= '0;
            pix_x_reg <= '0;
            pix_y_reg <= '0;
            de_reg    <= 1'b0;
            hsync_reg <= ~sh_hpol_reg;
            vsync_reg <= ~sh_vpol_reg;
          end else if (tick) begin
            dcnt_reg        <= '0;
            pix_tick_reg    <= 1'b1;
            pix_x_reg       <= h_nxt;
            pix_y_reg       <= v_nxt;
            line_start_reg  <= h_last;
            frame_start_reg <= frame_wrap;
            if (run_load) begin
              // (0,0) lies in both visible regions, so syncs take the new inactive level.
              de_reg    <= ~live_err;
              hsync_reg <= ~hpol_i;
              vsync_reg <= ~vpol_i;
              state_reg <= live_err ? IDLE : RUN;
            end else begin
              de_reg    <= de_nxt;
              hsync_reg <= hs_act ? sh_hpol_reg : ~sh_hpol_reg;
              vsync_reg <= vs_act ? sh_vpol_reg : ~sh_vpol_reg;
            end
          end else begin
            dcnt_reg <= dcnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign upd_ack_o     = upd_ack_reg;
  assign cfg_err_o     = sh_err_reg;
  assign pix_tick_o    = pix_tick_reg;
  assign pix_x_o       = pix_x_reg;
  assign pix_y_o       = pix_y_reg;
  assign de_o          = de_reg;
  assign hsync_o       = hsync_reg;
  assign vsync_o       = vsync_reg;
  assign line_start_o  = line_start_reg;
  assign frame_start_o = frame_start_reg;

endmodule
